// File: rtl/rx_frame_deserializer.sv
// Serial-to-parallel receive front end. Hunts for a sync pattern, collects one frame, and holds it
// for a valid/ack consumer. Optional trailing even-parity bit enabled by `define FRAME_PARITY_EN.
module rx_frame_deserializer #(
  parameter int unsigned       FRAME_W  = 84,
  parameter int unsigned       SYNC_W   = 8,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ser_in,
  input  logic               ser_en,
  input  logic               frame_ack,
  output logic [FRAME_W-1:0] rx_data,
  output logic               frame_valid,
  output logic               overrun,
  output logic               busy,
  output logic               parity_err
);

  localparam int unsigned      CntW    = $clog2(FRAME_W);
  localparam logic [CntW-1:0]  LastCnt = CntW'(FRAME_W - 1);

  typedef enum logic [1:0] {
    StHunt    = 2'd0,
`ifdef FRAME_PARITY_EN
    StParity  = 2'd2,
`endif
    StCollect = 2'd1
  } state_e;

  state_e              r_state, w_state_next;
  logic [SYNC_W-1:0]   r_sync, w_sync_shift;
  logic [FRAME_W-1:0]  r_payload, w_frame;
  logic [CntW-1:0]     r_cnt;
  logic [FRAME_W-1:0]  r_rx_data;
  logic                r_valid, r_overrun;
  logic                w_sync_hit, w_last_bit, w_complete, w_load;

  assign w_sync_shift = {r_sync[SYNC_W-2:0], ser_in};
  assign w_sync_hit   = ser_en && (w_sync_shift == SYNC_PAT);
  assign w_last_bit   = (r_state == StCollect) && ser_en && (r_cnt == LastCnt);

`ifdef FRAME_PARITY_EN
  logic r_parity_err;
  logic w_parity_next;
  // Completion waits for the trailing parity strobe; the payload is already fully shifted in.
  assign w_complete    = (r_state == StParity) && ser_en;
  assign w_frame       = r_payload;
  assign w_parity_next = ^{r_payload, ser_in};
  assign parity_err    = r_parity_err;
`else
  assign w_complete = w_last_bit;
  assign w_frame    = {r_payload[FRAME_W-2:0], ser_in};
  assign parity_err = 1'b0;
`endif

  // A held, unacknowledged frame blocks the load and turns completion into an overrun.
  assign w_load = w_complete && (!r_valid || frame_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StHunt;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StHunt: begin
        if (w_sync_hit) w_state_next = StCollect;
      end
      StCollect: begin
`ifdef FRAME_PARITY_EN
        if (w_last_bit) w_state_next = StParity;
`else
        if (w_last_bit) w_state_next = StHunt;
`endif
      end
`ifdef FRAME_PARITY_EN
      StParity: begin
        if (ser_en) w_state_next = StHunt;
      end
`endif
      default: w_state_next = StHunt;
    endcase
  end

  always_comb begin
    busy = (r_state != StHunt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync    <= '0;
      r_payload <= '0;
      r_cnt     <= '0;
    end else if (ser_en) begin
      if (r_state == StHunt) begin
        r_sync <= w_sync_shift;
        if (w_sync_hit) r_cnt <= '0;
      end else begin
        // Keeps the sync register cleared so HUNT always starts from an empty window.
        r_sync <= '0;
        if (r_state == StCollect) begin
          r_payload <= {r_payload[FRAME_W-2:0], ser_in};
          r_cnt     <= w_last_bit ? '0 : r_cnt + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_data <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_complete && !w_load;
      if (w_load) begin
        r_rx_data <= w_frame;
        r_valid   <= 1'b1;
      end else if (r_valid && frame_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef FRAME_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity_err <= 1'b0;
    end else if (w_load) begin
      r_parity_err <= w_parity_next;
    end
  end
`endif

  assign rx_data     = r_rx_data;
  assign frame_valid = r_valid;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_rx_frame_deserializer.sv
// Directed bench for rx_frame_deserializer: reset, framing, overrun/ack, and the optional parity bit.
module tb_rx_frame_deserializer;

  localparam int unsigned FW = 84;

  logic          clk = 1'b0;
  logic          rst, ser_in, ser_en, frame_ack;
  logic [FW-1:0] rx_data;
  logic          frame_valid, overrun, busy, parity_err;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic early_seen;

  always #5 clk = ~clk;

  rx_frame_deserializer dut (
    .clk        (clk),
    .rst        (rst),
    .ser_in     (ser_in),
    .ser_en     (ser_en),
    .frame_ack  (frame_ack),
    .rx_data    (rx_data),
    .frame_valid(frame_valid),
    .overrun    (overrun),
    .busy       (busy),
    .parity_err (parity_err)
  );

  task automatic strobe(input logic b, input logic ack);
    ser_in    = b;
    ser_en    = 1'b1;
    frame_ack = ack;
    @(posedge clk);
    #1;
    ser_en    = 1'b0;
    frame_ack = 1'b0;
  endtask

  task automatic idle(input int n, input logic ack);
    repeat (n) begin
      frame_ack = ack;
      @(posedge clk);
      #1;
      frame_ack = 1'b0;
    end
  endtask

  task automatic send_sync();
    logic [7:0] p;
    p = 8'hA5;
    for (int i = 7; i >= 0; i--) strobe(p[i], 1'b0);
  endtask

  task automatic send_payload(input logic [FW-1:0] d, input int n, input logic gaps);
    for (int i = 0; i < n; i++) begin
      strobe(d[FW-1-i], 1'b0);
      if (frame_valid) early_seen = 1'b1;
      if (gaps && (i % 11 == 5)) idle(2, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [FW-1:0] d, input logic ack_last, input logic gaps);
    early_seen = 1'b0;
`ifdef FRAME_PARITY_EN
    send_payload(d, FW, gaps);
    strobe(^d, ack_last);
`else
    send_payload(d, FW - 1, gaps);
    strobe(d[0], ack_last);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; ser_en = 1'b0; ser_in = 1'b0; frame_ack = 1'b0;
    #2;
    n_tests++;
    if (frame_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || rx_data !== '0) begin
      n_fail++;
      $display("FAIL por_outputs: valid=%b busy=%b ovr=%b data=%h, required all 0",
               frame_valid, busy, overrun, rx_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    send_sync();
    send_frame(84'hABC, 1'b0, 1'b0);
    send_sync();
    strobe(1'b1, 1'b0);
    strobe(1'b0, 1'b0);
    n_tests++;
    if (frame_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_state: valid=%b busy=%b, required 1 1", frame_valid, busy);
    end
    rst = 1'b1;
    #2;
    n_tests++;
    if (frame_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || rx_data !== '0 ||
        parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b busy=%b ovr=%b perr=%b data=%h, required all 0",
               frame_valid, busy, overrun, parity_err, rx_data);
    end
    #1;
    rst = 1'b0;
    idle(1, 1'b0);
  endtask

  task automatic test_basic_frame();
    logic [FW-1:0] d;
    d = 84'h123456789ABCDEF012345;
    send_sync();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_after_sync: got %b required 1", busy);
    end
    send_frame(d, 1'b0, 1'b0);
    n_tests++;
    if (frame_valid !== 1'b1 || rx_data !== d) begin
      n_fail++;
      $display("FAIL basic_frame: valid=%b data=%h, required 1 %h", frame_valid, rx_data, d);
    end
    n_tests++;
    if (busy !== 1'b0 || overrun !== 1'b0 || parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_flags: busy=%b ovr=%b perr=%b, required 0 0 0",
               busy, overrun, parity_err);
    end
    idle(1, 1'b1);
    n_tests++;
    if (frame_valid !== 1'b0 || rx_data !== d) begin
      n_fail++;
      $display("FAIL basic_ack: valid=%b data=%h, required 0 %h", frame_valid, rx_data, d);
    end
  endtask

  task automatic test_no_sync();
    logic       bad;
    logic [7:0] p;
    bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      strobe(1'b0, 1'b0);
      if (busy || frame_valid) bad = 1'b1;
      if (i % 25 == 0) idle(3, 1'b0);
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL no_sync_zeros: busy/valid seen=%b required 0", bad);
    end
    // Sync pattern presented without strobes must not be captured.
    p = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      ser_in = p[i];
      idle(1, 1'b0);
    end
    n_tests++;
    if (busy !== 1'b0 || frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL no_sync_unstrobed: busy=%b valid=%b, required 0 0", busy, frame_valid);
    end
  endtask

  task automatic test_overrun();
    logic [FW-1:0] d1, d2;
    d1 = 84'h1;
    d2 = 84'h2;
    send_sync();
    send_frame(d1, 1'b0, 1'b0);
    n_tests++;
    if (frame_valid !== 1'b1 || rx_data !== d1 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_first: valid=%b ovr=%b data=%h, required 1 0 %h",
               frame_valid, overrun, rx_data, d1);
    end
    send_sync();
    send_frame(d2, 1'b0, 1'b0);
    n_tests++;
    if (overrun !== 1'b1 || frame_valid !== 1'b1 || rx_data !== d1) begin
      n_fail++;
      $display("FAIL ovr_pulse: ovr=%b valid=%b data=%h, required 1 1 %h",
               overrun, frame_valid, rx_data, d1);
    end
    idle(1, 1'b0);
    n_tests++;
    if (overrun !== 1'b0 || frame_valid !== 1'b1 || rx_data !== d1) begin
      n_fail++;
      $display("FAIL ovr_one_cycle: ovr=%b valid=%b data=%h, required 0 1 %h",
               overrun, frame_valid, rx_data, d1);
    end
    send_sync();
    send_frame(d2, 1'b1, 1'b0);
    n_tests++;
    if (overrun !== 1'b0 || frame_valid !== 1'b1 || rx_data !== d2) begin
      n_fail++;
      $display("FAIL ovr_ack_same_cycle: ovr=%b valid=%b data=%h, required 0 1 %h",
               overrun, frame_valid, rx_data, d2);
    end
    idle(1, 1'b1);
    idle(1, 1'b1);
    n_tests++;
    if (frame_valid !== 1'b0 || rx_data !== d2) begin
      n_fail++;
      $display("FAIL ack_when_empty: valid=%b data=%h, required 0 %h", frame_valid, rx_data, d2);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [FW-1:0] d;
    d = 84'hFFFFF00000FFFFF00000F;
    send_sync();
    early_seen = 1'b0;
    send_payload({FW{1'b1}}, 40, 1'b0);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_busy_before: got %b required 1", busy);
    end
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_cleared: busy=%b valid=%b, required 0 0", busy, frame_valid);
    end
    idle(1, 1'b0);
    send_sync();
    send_frame(d, 1'b0, 1'b1);
    n_tests++;
    if (early_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_early_frame: early valid=%b required 0", early_seen);
    end
    n_tests++;
    if (frame_valid !== 1'b1 || rx_data !== d) begin
      n_fail++;
      $display("FAIL midrst_frame: valid=%b data=%h, required 1 %h", frame_valid, rx_data, d);
    end
    idle(1, 1'b1);
  endtask

  task automatic test_parity();
    logic [FW-1:0] d;
    d = 84'h1;
`ifdef FRAME_PARITY_EN
    send_sync();
    send_payload(d, FW, 1'b0);
    n_tests++;
    if (busy !== 1'b1 || frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL par_wait_state: busy=%b valid=%b, required 1 0", busy, frame_valid);
    end
    strobe(1'b1, 1'b0);
    n_tests++;
    if (frame_valid !== 1'b1 || rx_data !== d || parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL par_good: valid=%b perr=%b data=%h, required 1 0 %h",
               frame_valid, parity_err, rx_data, d);
    end
    idle(1, 1'b1);
    send_sync();
    send_payload(d, FW, 1'b0);
    strobe(1'b0, 1'b0);
    n_tests++;
    if (frame_valid !== 1'b1 || parity_err !== 1'b1) begin
      n_fail++;
      $display("FAIL par_bad: valid=%b perr=%b, required 1 1", frame_valid, parity_err);
    end
    idle(1, 1'b1);
`else
    send_sync();
    send_frame(d, 1'b0, 1'b0);
    n_tests++;
    if (frame_valid !== 1'b1 || rx_data !== d || parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL par_disabled: valid=%b perr=%b data=%h, required 1 0 %h",
               frame_valid, parity_err, rx_data, d);
    end
    idle(1, 1'b1);
`endif
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_no_sync();
    test_overrun();
    test_reset_mid_frame();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
